// File: rtl/mbssoc_int_receiver.sv
// Per-core interrupt receiver: takes a controller request or syscall at an instruction boundary,
// saves EPC, redirects fetch to the vector entry and returns to EPC on eret.
module mbssoc_int_receiver #(
   parameter int unsigned           INT_SEL_WIDTH = 8,
   parameter int unsigned           ADDR_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] VEC_BASE      = ADDR_WIDTH'(32'h40),
   parameter int unsigned           VEC_STRIDE    = 4,
   parameter logic [ADDR_WIDTH-1:0] SYSCALL_VEC   = ADDR_WIDTH'(32'h3C)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     int_req,
   input  logic [INT_SEL_WIDTH-1:0] int_num,
   input  logic                     syscall_req,
   input  logic                     retire,
   input  logic [ADDR_WIDTH-1:0]    retire_pc,
   input  logic                     eret,
   input  logic                     ie,
   output logic                     int_able,
   output logic                     redirect,
   output logic [ADDR_WIDTH-1:0]    redirect_pc,
   output logic [ADDR_WIDTH-1:0]    epc,
   output logic [INT_SEL_WIDTH:0]   cause,
   output logic                     in_handler,
   output logic                     overflow
);

   typedef enum logic [2:0] {StIdle, StPending, StRedirect, StHandler, StReturn} state_e;

   state_e                   state_q;
   logic                     int_req_q;
   logic                     pend_valid_q;
   logic [INT_SEL_WIDTH-1:0] pend_num_q;

   logic                  req_rise;
   logic                  take_sys;
   logic                  take_int;
   logic                  pend_free;
   logic                  latch;
   logic                  pend_next;
   logic [ADDR_WIDTH-1:0] int_vec;

   always_comb begin
      req_rise  = int_req & ~int_req_q;
      // Syscalls ignore ie and win over a pending interrupt at the same boundary.
      take_sys  = retire & syscall_req & ((state_q == StIdle) | (state_q == StPending));
      take_int  = retire & ie & ~syscall_req & (state_q == StPending) & pend_valid_q;
      // The slot may be refilled in the same cycle its occupant is taken.
      pend_free = ~pend_valid_q | take_int;
      latch     = req_rise & pend_free;
      pend_next = latch | (pend_valid_q & ~take_int);
      int_vec   = VEC_BASE + ADDR_WIDTH'(pend_num_q) * ADDR_WIDTH'(VEC_STRIDE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         int_req_q    <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_num_q   <= '0;
         int_able     <= 1'b0;
         redirect     <= 1'b0;
         redirect_pc  <= '0;
         epc          <= '0;
         cause        <= '0;
         in_handler   <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         int_req_q    <= int_req;
         pend_valid_q <= pend_next;
         if (latch) begin
            pend_num_q <= int_num;
         end
         if (req_rise && !pend_free) begin
            overflow <= 1'b1;
         end
         int_able   <= ie & (state_q == StIdle) & ~pend_valid_q;
         redirect   <= 1'b0;
         in_handler <= 1'b0;

         unique case (state_q)
            StIdle, StPending: begin
               if (take_sys) begin
                  epc         <= retire_pc;
                  cause       <= {1'b1, int_num};
                  redirect    <= 1'b1;
                  redirect_pc <= SYSCALL_VEC;
                  state_q     <= StRedirect;
               end else if (take_int) begin
                  epc         <= retire_pc;
                  cause       <= {1'b0, pend_num_q};
                  redirect    <= 1'b1;
                  redirect_pc <= int_vec;
                  state_q     <= StRedirect;
               end else if (pend_next) begin
                  state_q <= StPending;
               end
            end
            StRedirect: begin
               in_handler <= 1'b1;
               state_q    <= StHandler;
            end
            StHandler: begin
               if (eret) begin
                  redirect    <= 1'b1;
                  redirect_pc <= epc;
                  state_q     <= StReturn;
               end else begin
                  in_handler <= 1'b1;
               end
            end
            StReturn: begin
               state_q <= pend_next ? StPending : StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbssoc_int_receiver.sv
// Directed bench for mbssoc_int_receiver; every redirect pulse is checked against a queue of
// expected {pc, cause, epc} entries pushed as the stimulus is applied.
module tb_mbssoc_int_receiver;

   logic        clk;
   logic        rst_n;
   logic        int_req;
   logic [7:0]  int_num;
   logic        syscall_req;
   logic        retire;
   logic [31:0] retire_pc;
   logic        eret;
   logic        ie;
   logic        int_able;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic [8:0]  cause;
   logic        in_handler;
   logic        overflow;

   typedef struct packed {
      logic [31:0] pc;
      logic [8:0]  cause;
      logic [31:0] epc;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   mbssoc_int_receiver dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .int_req     (int_req),
      .int_num     (int_num),
      .syscall_req (syscall_req),
      .retire      (retire),
      .retire_pc   (retire_pc),
      .eret        (eret),
      .ie          (ie),
      .int_able    (int_able),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .epc         (epc),
      .cause       (cause),
      .in_handler  (in_handler),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_redir(input logic [31:0] pc, input logic [8:0] c, input logic [31:0] e);
      exp_t item;
      item.pc    = pc;
      item.cause = c;
      item.epc   = e;
      exp_q.push_back(item);
   endtask

   // One clock; outputs sampled on the falling edge, every redirect pulse consumes one entry.
   task automatic cyc();
      exp_t item;
      @(posedge clk);
      @(negedge clk);
      if (redirect) begin
         chk("redirect_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            chk("redir_pc", 64'(redirect_pc), 64'(item.pc));
            chk("redir_cause", 64'(cause), 64'(item.cause));
            chk("redir_epc", 64'(epc), 64'(item.epc));
         end
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      int_req     = 1'b0;
      int_num     = '0;
      syscall_req = 1'b0;
      retire      = 1'b0;
      retire_pc   = '0;
      eret        = 1'b0;
      ie          = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_int_able", 64'(int_able), 64'd0);
      chk("rst_redirect", 64'(redirect), 64'd0);
      chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
      chk("rst_epc", 64'(epc), 64'd0);
      chk("rst_cause", 64'(cause), 64'd0);
      chk("rst_in_handler", 64'(in_handler), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      cyc();
      chk("int_able_after_rst", 64'(int_able), 64'd1);

      // Basic interrupt 3, retire next cycle, redirect the cycle after.
      int_req = 1'b1; int_num = 8'd3;
      cyc();
      int_req = 1'b0; retire = 1'b1; retire_pc = 32'h100;
      expect_redir(32'h4C, 9'h003, 32'h100);
      cyc();
      chk("latency_redirect", 64'(redirect), 64'd1);
      retire = 1'b0;
      cyc();
      chk("in_handler_set", 64'(in_handler), 64'd1);
      chk("int_able_in_handler", 64'(int_able), 64'd0);

      // Interrupt 5 arrives during the handler and is taken after eret.
      int_req = 1'b1; int_num = 8'd5;
      cyc();
      int_req = 1'b0;
      cyc();
      eret = 1'b1;
      expect_redir(32'h100, 9'h003, 32'h100);
      cyc();
      chk("in_handler_clr_return", 64'(in_handler), 64'd0);
      eret = 1'b0;
      cyc();
      retire = 1'b1; retire_pc = 32'h200;
      expect_redir(32'h54, 9'h005, 32'h200);
      cyc();
      retire = 1'b0;
      cyc();

      // Two requests in the handler: the second finds the slot full and is dropped.
      int_req = 1'b1; int_num = 8'd9;
      cyc();
      int_req = 1'b0;
      cyc();
      chk("overflow_clear", 64'(overflow), 64'd0);
      int_req = 1'b1; int_num = 8'h0A;
      cyc();
      int_req = 1'b0;
      cyc();
      chk("overflow_set", 64'(overflow), 64'd1);
      eret = 1'b1;
      expect_redir(32'h200, 9'h005, 32'h200);
      cyc();
      eret = 1'b0;
      cyc();
      retire = 1'b1; retire_pc = 32'h300;
      expect_redir(32'h64, 9'h009, 32'h300);
      cyc();
      retire = 1'b0;
      cyc();
      eret = 1'b1;
      expect_redir(32'h300, 9'h009, 32'h300);
      cyc();
      eret = 1'b0;
      cyc();
      retire = 1'b1; retire_pc = 32'h304;
      cyc();
      retire = 1'b0;
      cyc();
      chk("int_able_idle_again", 64'(int_able), 64'd1);

      // Syscall at the same boundary as a pending interrupt 2: syscall first.
      int_req = 1'b1; int_num = 8'd2;
      cyc();
      int_req = 1'b0;
      cyc();
      retire = 1'b1; syscall_req = 1'b1; int_num = 8'h07; retire_pc = 32'h400;
      expect_redir(32'h3C, 9'h107, 32'h400);
      cyc();
      retire = 1'b0; syscall_req = 1'b0;
      cyc();
      eret = 1'b1;
      expect_redir(32'h400, 9'h107, 32'h400);
      cyc();
      eret = 1'b0;
      cyc();
      retire = 1'b1; retire_pc = 32'h500;
      expect_redir(32'h48, 9'h002, 32'h500);
      cyc();
      retire = 1'b0;
      cyc();
      eret = 1'b1;
      expect_redir(32'h500, 9'h002, 32'h500);
      cyc();
      eret = 1'b0;
      cyc();

      // ie=0: request latched but held until ie returns; eret outside the handler is ignored.
      ie = 1'b0;
      cyc();
      cyc();
      chk("int_able_ie0", 64'(int_able), 64'd0);
      int_req = 1'b1; int_num = 8'd4;
      cyc();
      int_req = 1'b0; retire = 1'b1; retire_pc = 32'h600;
      cyc();
      retire = 1'b0;
      eret = 1'b1;
      cyc();
      eret = 1'b0;
      ie = 1'b1;
      cyc();
      chk("ie0_no_handler", 64'(in_handler), 64'd0);
      retire = 1'b1; retire_pc = 32'h700;
      expect_redir(32'h50, 9'h004, 32'h700);
      cyc();
      retire = 1'b0;
      cyc();
      eret = 1'b1;
      expect_redir(32'h700, 9'h004, 32'h700);
      cyc();
      eret = 1'b0;
      cyc();
      cyc();
      eret = 1'b1;
      cyc();
      eret = 1'b0;
      cyc();
      chk("int_able_after_idle_eret", 64'(int_able), 64'd1);

      // Asynchronous reset in the middle of a handler.
      int_req = 1'b1; int_num = 8'd1;
      cyc();
      int_req = 1'b0; retire = 1'b1; retire_pc = 32'h800;
      expect_redir(32'h44, 9'h001, 32'h800);
      cyc();
      retire = 1'b0;
      cyc();
      chk("pre_rst_in_handler", 64'(in_handler), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_in_handler", 64'(in_handler), 64'd0);
      chk("async_overflow", 64'(overflow), 64'd0);
      chk("async_epc", 64'(epc), 64'd0);
      chk("async_cause", 64'(cause), 64'd0);
      chk("async_redirect_pc", 64'(redirect_pc), 64'd0);
      chk("async_int_able", 64'(int_able), 64'd0);
      eret = 1'b1;
      cyc();
      eret = 1'b0;
      rst_n = 1'b1;
      chk("int_able_at_release", 64'(int_able), 64'd0);
      cyc();
      chk("int_able_one_after_release", 64'(int_able), 64'd1);
      eret = 1'b1;
      cyc();
      eret = 1'b0;
      cyc();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
